digit_overlay: RTL and testbench

//  Inverse of the segmentation path: takes six 4-bit digit codes and renders them as seven-segment

---
 rtl/seg_pkg.sv | 42 ++++
 rtl/seven_seg_rom.sv | 26 ++
 rtl/digit_overlay.sv | 167 ++++++++++++++++
 tb/tb_digit_overlay.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment window geometry and seven-segment masks shared with the segmentation block
package seg_pkg;

    localparam int RGB_W   = 12;
    localparam int NUM_WIN = 6;
    localparam int V_TOP   = 150;
    localparam int V_BOT   = 300;
    localparam int WIN_W   = 75;
    localparam int WIN_H   = 150;
    localparam int V_MID   = 75;

    // Masks are {a,b,c,d,e,f,g}, a in the MSB.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        BUF_IDLE,
        BUF_FULL
    } buf_state_t;

    // Left edge (exclusive) of each window; window k covers H0 < hcnt < H0+WIN_W.
    function automatic logic [9:0] win_h0(input logic [2:0] k);
        case (k)
            3'd0:    win_h0 = 10'd50;
            3'd1:    win_h0 = 10'd140;
            3'd2:    win_h0 = 10'd230;
            3'd3:    win_h0 = 10'd335;
            3'd4:    win_h0 = 10'd425;
            default: win_h0 = 10'd515;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_rom.sv
// rtl/seven_seg_rom.sv - 4-bit digit code to {a..g} segment mask, blank for codes 10..15
module seven_seg_rom
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] mask
);

    always_comb begin
        mask = SEG_BLANK;
        case (code)
            4'd0:    mask = SEG_0;
            4'd1:    mask = SEG_1;
            4'd2:    mask = SEG_2;
            4'd3:    mask = SEG_3;
            4'd4:    mask = SEG_4;
            4'd5:    mask = SEG_5;
            4'd6:    mask = SEG_6;
            4'd7:    mask = SEG_7;
            4'd8:    mask = SEG_8;
            4'd9:    mask = SEG_9;
            default: mask = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/digit_overlay.sv
// rtl/digit_overlay.sv - renders six seven-segment glyphs onto the VGA pixel stream
module digit_overlay
    import seg_pkg::*;
#(
    parameter int               STROKE   = 8,
    parameter logic [RGB_W-1:0] FG_COLOR = 12'hF00,
    parameter bit               BG_MASK  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       hcnt,
    input  logic [9:0]       vcnt,
    input  logic [RGB_W-1:0] pixel_in,
    input  logic [23:0]      digit_in,
    input  logic             digit_valid,
    output logic             digit_ready,
    output logic             frame_start,
    output logic [RGB_W-1:0] pixel_out
);

    localparam logic [9:0] ST_W   = 10'(STROKE);
    localparam logic [9:0] D_LO   = 10'(WIN_H - STROKE);
    localparam logic [9:0] G_LO   = 10'(V_MID - STROKE / 2);
    localparam logic [9:0] G_HI   = 10'(V_MID + STROKE / 2);
    localparam logic [9:0] R_LO   = 10'(WIN_W - 1 - STROKE);
    localparam logic [9:0] MID_W  = 10'(V_MID);

    buf_state_t state, next_state;
    logic        load_shadow, swap_active, boundary;
    logic [23:0] shadow, active;

    assign boundary    = (hcnt == 10'd0) && (vcnt == 10'd0);
    assign digit_ready = (state == BUF_IDLE);

    always_comb begin
        next_state  = state;
        load_shadow = 1'b0;
        swap_active = 1'b0;
        case (state)
            BUF_IDLE: begin
                // A load landing on the boundary only fills the shadow; it shows next frame.
                if (digit_valid) begin
                    load_shadow = 1'b1;
                    next_state  = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (boundary) begin
                    swap_active = 1'b1;
                    next_state  = BUF_IDLE;
                end
            end
            default: next_state = BUF_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BUF_IDLE;
            shadow      <= 24'h0;
            active      <= 24'hFFFFFF;
            frame_start <= 1'b0;
        end else begin
            state       <= next_state;
            frame_start <= boundary;
            if (load_shadow) shadow <= digit_in;
            if (swap_active) active <= shadow;
        end
    end

    // Stage 1: window hit and local coordinates.
    logic       win_hit, v_in;
    logic [2:0] win_k;
    logic [9:0] h0;
    logic [6:0] lx;
    logic [7:0] ly;

    always_comb begin
        win_hit = 1'b0;
        win_k   = 3'd0;
        h0      = 10'd0;
        lx      = 7'd0;
        ly      = 8'd0;
        v_in    = (vcnt > 10'(V_TOP)) && (vcnt <= 10'(V_BOT));
        for (int k = 0; k < NUM_WIN; k++) begin
            h0 = win_h0(3'(k));
            if (v_in && (hcnt > h0) && (hcnt < h0 + 10'(WIN_W))) begin
                win_hit = 1'b1;
                win_k   = 3'(k);
                lx      = 7'(hcnt - h0 - 10'd1);
                ly      = 8'(vcnt - 10'(V_TOP + 1));
            end
        end
    end

    logic             s1_hit;
    logic [2:0]       s1_k;
    logic [6:0]       s1_lx;
    logic [7:0]       s1_ly;
    logic [RGB_W-1:0] s1_pix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_hit <= 1'b0;
            s1_k   <= 3'd0;
            s1_lx  <= 7'd0;
            s1_ly  <= 8'd0;
            s1_pix <= '0;
        end else begin
            s1_hit <= win_hit;
            s1_k   <= win_k;
            s1_lx  <= lx;
            s1_ly  <= ly;
            s1_pix <= pixel_in;
        end
    end

    // Stage 2: glyph lookup and colour select.
    logic [3:0] code;
    logic [6:0] mask, seg_hit;
    logic [9:0] lx_w, ly_w;
    logic       upper, lit;

    always_comb begin
        case (s1_k)
            3'd0:    code = active[3:0];
            3'd1:    code = active[7:4];
            3'd2:    code = active[11:8];
            3'd3:    code = active[15:12];
            3'd4:    code = active[19:16];
            3'd5:    code = active[23:20];
            default: code = 4'hF;
        endcase
    end

    seven_seg_rom u_rom (
        .code (code),
        .mask (mask)
    );

    always_comb begin
        lx_w    = {3'd0, s1_lx};
        ly_w    = {2'd0, s1_ly};
        upper   = ly_w < MID_W;
        seg_hit = {
            ly_w < ST_W,
            (lx_w >= R_LO) && upper,
            (lx_w >= R_LO) && !upper,
            ly_w >= D_LO,
            (lx_w < ST_W) && !upper,
            (lx_w < ST_W) && upper,
            (ly_w >= G_LO) && (ly_w < G_HI)
        };
        lit = |(mask & seg_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_out <= '0;
        end else if (s1_hit) begin
            pixel_out <= lit ? FG_COLOR : s1_pix;
        end else begin
            pixel_out <= BG_MASK ? '0 : s1_pix;
        end
    end

endmodule

// File: tb/tb_digit_overlay.sv
// tb/tb_digit_overlay.sv - randomized scoreboard bench for digit_overlay against a glyph reference model
module tb_digit_overlay;

    localparam int          STROKE = 8;
    localparam logic [11:0] FG     = 12'hF00;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hcnt, vcnt;
    logic [11:0] pixel_in;
    logic [23:0] digit_in;
    logic        digit_valid;
    logic        digit_ready, frame_start;
    logic [11:0] pixel_out;

    digit_overlay #(.STROKE(STROKE), .FG_COLOR(FG), .BG_MASK(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .pixel_in    (pixel_in),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .frame_start (frame_start),
        .pixel_out   (pixel_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          is_pix;
        logic [11:0] pix;
        logic        rdy;
        logic        fs;
    } exp_t;

    exp_t  sb[$];
    exp_t  mon_e;
    int    edge_cnt = 0;
    int    checks = 0;
    int    errors = 0;

    int    H0[6]    = '{50, 140, 230, 335, 425, 515};
    string SEGS[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                        "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    int act[6];
    int shadow_m[6];
    bit full_m;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic bit seg_on(byte c, int lx, int ly);
        case (c)
            "a":     return ly < STROKE;
            "d":     return ly >= 150 - STROKE;
            "g":     return (ly >= 75 - STROKE / 2) && (ly < 75 + STROKE / 2);
            "f":     return (lx < STROKE) && (ly < 75);
            "b":     return (lx >= 74 - STROKE) && (ly < 75);
            "e":     return (lx < STROKE) && (ly >= 75);
            "c":     return (lx >= 74 - STROKE) && (ly >= 75);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [11:0] model_pix(int h, int v, logic [11:0] p);
        int d, lx, ly;
        bit lit;
        for (int k = 0; k < 6; k++) begin
            if (h > H0[k] && h < H0[k] + 75 && v > 150 && v <= 300) begin
                lx  = h - H0[k] - 1;
                ly  = v - 151;
                d   = act[k];
                lit = 1'b0;
                if (d < 10)
                    for (int i = 0; i < SEGS[d].len(); i++)
                        if (seg_on(SEGS[d][i], lx, ly)) lit = 1'b1;
                return lit ? FG : p;
            end
        end
        return 12'h000;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 6; k++) begin
            act[k]      = 15;
            shadow_m[k] = 0;
        end
        full_m = 1'b0;
    endtask

    task automatic cyc(int h, int v, logic [11:0] p, bit dv, logic [23:0] din);
        exp_t pe, ce;
        bit   bnd;
        hcnt        = 10'(h);
        vcnt        = 10'(v);
        pixel_in    = p;
        digit_valid = dv;
        digit_in    = din;
        pe.due = edge_cnt + 2; pe.is_pix = 1'b1; pe.pix = model_pix(h, v, p);
        pe.rdy = 1'b0; pe.fs = 1'b0;
        bnd = (h == 0) && (v == 0);
        if (full_m && bnd) begin
            act    = shadow_m;
            full_m = 1'b0;
        end else if (!full_m && dv) begin
            for (int k = 0; k < 6; k++) shadow_m[k] = int'(din[4*k +: 4]);
            full_m = 1'b1;
        end
        ce.due = edge_cnt + 1; ce.is_pix = 1'b0; ce.pix = 12'h0;
        ce.rdy = !full_m; ce.fs = bnd;
        sb.push_back(ce);
        sb.push_back(pe);
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_cyc(bit dv);
        cyc($urandom_range(30, 620), $urandom_range(130, 320), 12'($urandom), dv, 24'($urandom));
    endtask

    task automatic check(string name, logic [11:0] got, logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
                mon_e = sb.pop_front();
                checks++;
                if (mon_e.is_pix) begin
                    if (pixel_out !== mon_e.pix) begin
                        errors++;
                        $display("FAIL pixel_out edge %0d: got %h expected %h", mon_e.due, pixel_out, mon_e.pix);
                    end
                end else if ({digit_ready, frame_start} !== {mon_e.rdy, mon_e.fs}) begin
                    errors++;
                    $display("FAIL ready/frame_start edge %0d: got %b%b expected %b%b",
                             mon_e.due, digit_ready, frame_start, mon_e.rdy, mon_e.fs);
                end
            end
        end
    end

    initial begin
        model_reset();
        rst = 1'b1; hcnt = 10'd0; vcnt = 10'd0; pixel_in = 12'h0;
        digit_in = 24'h0; digit_valid = 1'b0;
        #2;
        check("reset pixel_out", pixel_out, 12'h000);
        check("reset frame_start", 12'(frame_start), 12'h0);
        check("reset digit_ready", 12'(digit_ready), 12'h1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        cyc(0, 0, 12'($urandom), 0, 24'h0);
        repeat (300) rnd_cyc(0);
        cyc(0, 0, 12'($urandom), 0, 24'h0);
        repeat (100) rnd_cyc(0);

        // Mid-frame load: stays in shadow, later valids ignored until the boundary.
        cyc(300, 200, 12'($urandom), 1, 24'h876543);
        cyc(51, 151, 12'h0AB, 0, 24'h0);
        repeat (50) rnd_cyc(1);
        cyc(0, 0, 12'h0, 0, 24'h0);
        cyc(51, 151, 12'h0AB, 0, 24'h0);
        cyc(90, 200, 12'h123, 0, 24'h0);
        repeat (200) rnd_cyc(0);

        cyc(10, 10, 12'h0, 1, 24'hCCCC18);
        cyc(0, 0, 12'h0, 0, 24'h0);
        cyc(51, 151, 12'h0AB, 0, 24'h0);
        cyc(90, 200, 12'h123, 0, 24'h0);
        cyc(214, 160, 12'h456, 0, 24'h0);
        cyc(141, 160, 12'h789, 0, 24'h0);
        cyc(231, 151, 12'h0CD, 0, 24'h0);
        repeat (200) rnd_cyc(0);

        // Load on the boundary cycle with shadow empty.
        cyc(0, 0, 12'h0, 1, 24'h012345);
        cyc(51, 151, 12'h0AB, 0, 24'h0);
        repeat (200) rnd_cyc(0);
        cyc(0, 0, 12'h0, 0, 24'h0);
        cyc(51, 151, 12'h0AB, 0, 24'h0);
        repeat (200) rnd_cyc(0);

        repeat (3000) begin
            if ($urandom_range(0, 99) < 3)
                cyc(0, 0, 12'($urandom), 1'($urandom_range(0, 1)), 24'($urandom));
            else
                rnd_cyc($urandom_range(0, 9) == 0);
        end

        // Asynchronous reset mid-frame with a loaded shadow.
        cyc(0, 0, 12'h0, 0, 24'h0);
        cyc(55, 200, 12'($urandom) | 12'h001, 1, 24'h111111);
        cyc(56, 200, 12'($urandom) | 12'h001, 0, 24'h0);
        rst = 1'b1;
        #1;
        check("async reset pixel_out", pixel_out, 12'h000);
        check("async reset frame_start", 12'(frame_start), 12'h0);
        check("async reset digit_ready", 12'(digit_ready), 12'h1);
        sb.delete();
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cyc(0, 0, 12'h0, 0, 24'h0);
        repeat (300) rnd_cyc(0);

        repeat (4) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
